// File: rtl/brg_sram_march_pkg.sv
// Shared types and March C- element tables for the SRAM self-test initiator.
// Each table is a bit vector indexed by elem_e, so bit i describes element Mi.
package brg_sram_march_pkg;

  localparam int unsigned ELEM_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef enum logic [ELEM_W-1:0] {M0, M1, M2, M3, M4, M5} elem_e;

  // 1 = element walks addresses downward
  localparam logic [7:0] ELEM_DN   = 8'b0011_1000;
  // 1 = element starts each address with a read
  localparam logic [7:0] HAS_READ  = 8'b0011_1110;
  // 1 = element writes each address
  localparam logic [7:0] HAS_WRITE = 8'b0001_1111;
  // Read background: 1 = all-ones expected
  localparam logic [7:0] RD_BG     = 8'b0001_0100;
  // Write background: 1 = all-ones written
  localparam logic [7:0] WR_BG     = 8'b0000_1010;

endpackage

// File: rtl/brg_sram_march_addr_gen.sv
// Up/down address counter for the March walk.
// Ports: load_i reloads to the start of an element (load_dn_i picks top or 0),
// step_i moves one word in direction dn_i, term_c flags the last address of
// the current walk. The counter never wraps: the top address is els_p-1.
module brg_sram_march_addr_gen #(
  parameter int unsigned els_p         = 1024,
  parameter int unsigned addr_width_lp = 10
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     load_i,
  input  logic                     load_dn_i,
  input  logic                     step_i,
  input  logic                     dn_i,
  output logic [addr_width_lp-1:0] addr_o,
  output logic                     term_c
);

  localparam logic [addr_width_lp-1:0] TOP = addr_width_lp'(els_p - 1);

  // Terminal address depends on the direction of the element being walked
  always_comb begin
    term_c = dn_i ? (addr_o == '0) : (addr_o == TOP);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_o <= '0;
    end else if (load_i) begin
      addr_o <= load_dn_i ? TOP : '0;
    end else if (step_i) begin
      addr_o <= dn_i ? (addr_o - addr_width_lp'(1)) : (addr_o + addr_width_lp'(1));
    end
  end

endmodule

// File: rtl/brg_sram_march_initiator.sv
// March C- self-test requester for a 1-port synchronous SRAM.
// Ports: start_i launches a test (accepted in IDLE/DONE); busy_o/done_o/pass_o
// report status; fail_elem_o/fail_addr_o/fail_data_o hold the first mismatch;
// v_o/w_o/addr_o/data_o form the SRAM request; data_i is read data returned
// the cycle after a read request.
module brg_sram_march_initiator
  import brg_sram_march_pkg::*;
#(
  parameter int unsigned width_p       = 46,
  parameter int unsigned els_p         = 1024,
  parameter int unsigned addr_width_lp = 10
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [ELEM_W-1:0]        fail_elem_o,
  output logic [addr_width_lp-1:0] fail_addr_o,
  output logic [width_p-1:0]       fail_data_o,
  output logic                     v_o,
  output logic                     w_o,
  output logic [addr_width_lp-1:0] addr_o,
  output logic [width_p-1:0]       data_o,
  input  logic [width_p-1:0]       data_i
);

  state_e state_q, state_n;
  elem_e  elem_q, elem_n;
  logic   w_n;
  logic   ag_load_c, ag_load_dn_c, ag_step_c, term_c;
  logic   start_ok_c, mismatch_c, fail_n;

  logic                     rd_pend_q;
  logic                     rd_exp_q;
  elem_e                    rd_elem_q;
  logic [addr_width_lp-1:0] rd_addr_q;
  logic                     fail_q;

  brg_sram_march_addr_gen #(
    .els_p        (els_p),
    .addr_width_lp(addr_width_lp)
  ) u_addr_gen (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (ag_load_c),
    .load_dn_i(ag_load_dn_c),
    .step_i   (ag_step_c),
    .dn_i     (ELEM_DN[elem_q]),
    .addr_o   (addr_o),
    .term_c   (term_c)
  );

  assign start_ok_c = start_i && ((state_q == IDLE) || (state_q == DONE));
  // Only the cycle after a read carries meaningful data_i
  assign mismatch_c = rd_pend_q && (data_i != {width_p{rd_exp_q}});
  assign fail_n     = start_ok_c ? 1'b0 : (fail_q | mismatch_c);

  // State and element registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      elem_q  <= M0;
    end else begin
      state_q <= state_n;
      elem_q  <= elem_n;
    end
  end

  // Next-state: pick the next request (read->write at same address, else step or next element)
  always_comb begin
    state_n      = state_q;
    elem_n       = elem_q;
    w_n          = 1'b0;
    ag_load_c    = 1'b0;
    ag_load_dn_c = 1'b0;
    ag_step_c    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok_c) begin
          state_n      = RUN;
          elem_n       = M0;
          ag_load_c    = 1'b1;
          ag_load_dn_c = ELEM_DN[M0];
          w_n          = ~HAS_READ[M0];
        end
      end
      RUN: begin
        if (!w_o && HAS_WRITE[elem_q]) begin
          w_n = 1'b1;
        end else if (!term_c) begin
          ag_step_c = 1'b1;
          w_n       = ~HAS_READ[elem_q];
        end else if (elem_q == M5) begin
          state_n = DRAIN;
        end else begin
          elem_n       = elem_e'(elem_q + ELEM_W'(1));
          ag_load_c    = 1'b1;
          ag_load_dn_c = ELEM_DN[elem_n];
          w_n          = ~HAS_READ[elem_n];
        end
      end
      DRAIN:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Registered request, status, read pipeline and first-failure capture
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o         <= 1'b0;
      w_o         <= 1'b0;
      data_o      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_exp_q    <= 1'b0;
      rd_elem_q   <= M0;
      rd_addr_q   <= '0;
      fail_q      <= 1'b0;
      fail_elem_o <= '0;
      fail_addr_o <= '0;
      fail_data_o <= '0;
    end else begin
      v_o       <= (state_n == RUN);
      w_o       <= w_n;
      data_o    <= {width_p{w_n & WR_BG[elem_n]}};
      busy_o    <= (state_n == RUN) || (state_n == DRAIN);
      done_o    <= (state_n == DONE);
      pass_o    <= (state_n == DONE) && !fail_n;
      rd_pend_q <= v_o && !w_o;
      rd_exp_q  <= RD_BG[elem_q];
      rd_elem_q <= elem_q;
      rd_addr_q <= addr_o;
      fail_q    <= fail_n;
      if (start_ok_c) begin
        fail_elem_o <= '0;
        fail_addr_o <= '0;
        fail_data_o <= '0;
      end else if (mismatch_c && !fail_q) begin
        fail_elem_o <= rd_elem_q;
        fail_addr_o <= rd_addr_q;
        fail_data_o <= data_i;
      end
    end
  end

endmodule
